uart_mem_dump_tx: RTL and testbench
===================================

UART_MEM_DUMP_TX -- requirements
Module: uart_mem_dump_tx

Interface
- REQ-001: Parameter DBITS, default 8, sets data bits per UART frame.
- REQ-002: Parameter SB_TICK, default 16, sets stop-bit length in sample ticks.
- REQ-003: Parameter AW, default 10, sets memory word-address width.
- REQ-004: clk_100MHz  input  1  system clock; all state updates on its rising edge.
- REQ-005: rst  input  1  synchronous, active-high reset.
- REQ-006: sample_tick  input  1  16x-baud enable pulse from the baud generator, one clk wide.
- REQ-007: start  input  1  dump request, sampled in IDLE only.
- REQ-008: start_addr  input  AW  first word address to dump.
- REQ-009: word_count  input  AW+1  number of 32-bit words to dump, 0..2^AW.
- REQ-010: mem_addr  output  AW  word address to the instruction memory read port.
- REQ-011: mem_rd_data  input  32  memory read data, valid one clk after mem_addr.
- REQ-012: tx  output  1  UART serial line, idle high.
- REQ-013: busy  output  1  high from the cycle after start is accepted until done.
- REQ-014: done  output  1  one-clk pulse when the dump completes.

Function
- REQ-015: States are IDLE, FETCH, LATCH, START, DATA, STOP and NEXT.
- REQ-016: Transitions:
  - IDLE->FETCH on start with word_count!=0; latch start_addr and word_count.
  - FETCH->LATCH after 1 clk, driving mem_addr.
  - LATCH->START after 1 clk; capture mem_rd_data into the 32-bit shift word; byte index = 0.
- REQ-017: START drives tx=0 for 16 sample_ticks, then moves to DATA.
- REQ-018: DATA sends DBITS bits LSB first, each held for 16 sample_ticks, then moves to STOP.
- REQ-019: STOP drives tx=1 for SB_TICK sample_ticks, then moves to NEXT.
- REQ-020: Tick and bit counters advance only on cycles where sample_tick=1; the state does not change without a tick, except in FETCH, LATCH and NEXT.
- REQ-021: Bytes of each word go little-endian: [7:0], [15:8], [23:16], [31:24].
- REQ-022: NEXT decides what follows, in one clk:
  - byte index <3: increment it and go to START.
  - otherwise, remaining words >1: decrement remaining, increment mem_addr, go to FETCH.
  - otherwise: pulse done and go to IDLE.
- REQ-023: mem_addr increments modulo 2^AW; 2^AW-1 wraps to 0.
- REQ-024: start with word_count=0 sends no frame, keeps tx=1 and busy=0, and pulses done the next clk.
- REQ-025: start is ignored while busy=1; start_addr and word_count changes mid-dump have no effect.
- REQ-026: tx is registered and glitch-free; it changes only on state or bit boundaries.
- REQ-027: Latency from start accepted (cycle N) to the falling start-bit edge of tx is 3 clks (edge at N+3).
- REQ-028: Between consecutive frames, the only idle time beyond the stop bit is the NEXT/FETCH/LATCH cycles; the line stays high during them.

Reset
- REQ-029: With rst=1 at a clock edge: state IDLE, tx=1, busy=0, done=0, mem_addr=0, all counters 0.
- REQ-030: rst asserted mid-frame returns the block to IDLE at the next edge, with tx=1 in the same cycle; the partial frame is abandoned and done is not pulsed.

Verification
- REQ-031: sample_tick tied 1, mem[5]=0x000000A5, start_addr=5, word_count=1. Required response:
  - tx shows 16-clk bits 0,1,0,1,0,0,1,0,1,1 for byte 0xA5, then three frames of 0x00.
  - done pulses once; busy is high throughout.
- REQ-032: mem[1023]=0x11223344, mem[0]=0x55667788, start_addr=1023, word_count=2. Required response:
  - mem_addr sequence is 1023 then 0.
  - Bytes seen on tx: 44,33,22,11,88,77,66,55.
- REQ-033: word_count=0 with start=1. Required response: done=1 exactly one clk later, tx=1, busy=0, no memory access needed.
- REQ-034: start pulsed again during byte 2 of a 1-word dump. Required response: exactly 4 frames, one done pulse, no restart.
- REQ-035: rst=1 during the DATA bit 3 of the first frame. Required response: tx=1 and busy=0 next clk, done never asserted; a following start with word_count=1 dumps correctly.
- REQ-036: sample_tick every 3rd clk. Required response: each bit lasts 48 clks, and the stop bit lasts SB_TICK*3 clks.

Source files
------------

// File: rtl/uart_mem_dump_tx_if.sv
// Command/status handshake and instruction-memory read port of the memory dump transmitter.
interface uart_mem_dump_tx_if #(
    parameter int AW = 10
);
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rd_data;

    // Requester side: issues dumps and serves memory reads.
    modport master (
        output start, start_addr, word_count, mem_rd_data,
        input  busy, done, mem_addr
    );

    // Dump engine side.
    modport slave (
        input  start, start_addr, word_count, mem_rd_data,
        output busy, done, mem_addr
    );
endinterface

// File: rtl/uart_mem_dump_tx.sv
// Streams a range of 32-bit memory words out of a UART transmitter,
// four little-endian byte frames per word.
module uart_mem_dump_tx #(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16,
    parameter int AW      = 10
) (
    input  logic              clk_100MHz,
    input  logic              rst,
    input  logic              sample_tick,
    output logic              tx,
    uart_mem_dump_tx_if.slave bus
);

    localparam int TMAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int TW   = $clog2(TMAX);
    localparam int NW   = (DBITS > 1) ? $clog2(DBITS) : 1;

    localparam logic [TW-1:0] S_LAST  = TW'(15);
    localparam logic [TW-1:0] ST_LAST = TW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        DATA,
        STOP,
        NEXT
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    s_q, s_d;
    logic [NW-1:0]    n_q, n_d;
    logic [1:0]       idx_q, idx_d;
    logic [AW:0]      rem_q, rem_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [31:0]      word_q, word_d;
    logic [DBITS-1:0] sh_q, sh_d;
    logic             tx_q, tx_d;
    logic             busy_q;
    logic             done_q, done_d;

    assign tx           = tx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_addr = addr_q;

    // State and datapath registers; tx/busy/done are registered from next-state values.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

    // Next-state, counters and line level for the dump sequencer.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        word_d  = word_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.word_count != '0) begin
                        state_d = FETCH;
                        addr_d  = bus.start_addr;
                        rem_d   = bus.word_count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                word_d  = bus.mem_rd_data;
                idx_d   = '0;
                s_d     = '0;
                state_d = START;
            end
            START: begin
                if (sample_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        sh_d    = DBITS'(word_q >> {idx_q, 3'b000});
                        state_d = DATA;
                    end else begin
                        s_d = s_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (s_q == S_LAST) begin
                        s_d  = '0;
                        sh_d = sh_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + TW'(1);
                    end
                end
            end
            STOP: begin
                if (sample_tick) begin
                    if (s_q == ST_LAST) begin
                        s_d     = '0;
                        state_d = NEXT;
                    end else begin
                        s_d = s_q + TW'(1);
                    end
                end
            end
            NEXT: begin
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = START;
                end else if (rem_q > (AW+1)'(1)) begin
                    rem_d   = rem_q - (AW+1)'(1);
                    addr_d  = addr_q + AW'(1);
                    state_d = FETCH;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level follows the state being entered so tx stays a clean register output.
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = sh_d[0];
        end
    end

endmodule

// File: tb/tb_uart_mem_dump_tx.sv
// Directed bench for the UART memory dump transmitter: reset, frame timing, byte order,
// address wrap, empty dumps, ignored restarts, mid-frame reset and slow sample ticks.
module tb_uart_mem_dump_tx;
    localparam int AW      = 10;
    localparam int SB_TICK = 16;

    logic clk_100MHz  = 1'b0;
    logic rst         = 1'b1;
    logic sample_tick = 1'b0;
    logic tx;
    int   tick_div    = 1;
    int   tick_ph     = 0;

    int checks   = 0;
    int failures = 0;

    uart_mem_dump_tx_if #(.AW(AW)) bus ();

    uart_mem_dump_tx #(
        .DBITS  (8),
        .SB_TICK(SB_TICK),
        .AW     (AW)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .sample_tick(sample_tick),
        .tx         (tx),
        .bus        (bus)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Synchronous-read instruction memory: data valid one clock after the address.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk_100MHz) bus.mem_rd_data <= mem[bus.mem_addr];

    // Sample tick: one clock wide, every tick_div clocks.
    initial begin
        forever begin
            @(negedge clk_100MHz);
            tick_ph     = (tick_ph + 1) % tick_div;
            sample_tick = (tick_ph == 0);
        end
    end

    // Observers: done pulses, memory addresses, tx run lengths and a UART receiver.
    logic [7:0]    rx_q[$];
    int            rx_ferr = 0;
    int            done_cnt = 0;
    logic [AW-1:0] addr_q[$];
    logic          prev_busy = 1'b0;
    logic          run_lvl_q[$];
    int            run_len_q[$];
    logic          cur_lvl = 1'b1;
    int            cur_len = 0;
    logic          rx_act = 1'b0;
    int            rx_cnt = 0;
    logic [9:0]    rx_sh = '0;

    always @(negedge clk_100MHz) begin
        int k;
        int bl;
        bl = 16 * tick_div;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.busy === 1'b1 && (!prev_busy || addr_q.size() == 0 || bus.mem_addr != addr_q[$]))
            addr_q.push_back(bus.mem_addr);
        prev_busy = bus.busy;
        if (tx !== cur_lvl) begin
            run_lvl_q.push_back(cur_lvl);
            run_len_q.push_back(cur_len);
            cur_lvl = tx;
            cur_len = 1;
        end else begin
            cur_len++;
        end
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % bl == bl / 2) begin
                k = rx_cnt / bl;
                rx_sh[k] = tx;
                if (k == 9) begin
                    rx_q.push_back(rx_sh[8:1]);
                    if (rx_sh[9] !== 1'b1 || rx_sh[0] !== 1'b0) rx_ferr++;
                    rx_act = 1'b0;
                end
            end
        end
    end

    logic [7:0] exp_b[$];
    int         exp_run[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [AW:0] n);
        bus.start_addr = a;
        bus.word_count = n;
        bus.start      = 1'b1;
        @(negedge clk_100MHz);
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit, output int gaps);
        int  n;
        logic got;
        n    = 0;
        got  = 1'b0;
        gaps = 0;
        while (!got && n < limit) begin
            @(negedge clk_100MHz);
            n++;
            if (bus.done === 1'b1) got = 1'b1;
            else if (bus.busy !== 1'b1) gaps++;
        end
        check_eq({tag, "_done_seen"}, got, 1);
    endtask

    task automatic check_rx(input string tag, input int base);
        check_eq({tag, "_rx_count"}, rx_q.size() - base, exp_b.size());
        for (int i = 0; i < exp_b.size(); i++)
            if (base + i < rx_q.size())
                check_eq($sformatf("%s_rx_byte%0d", tag, i), rx_q[base + i], exp_b[i]);
    endtask

    initial begin
        int rb, db, ab, fb, lb, gaps, lat, n;
        logic seen;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[5]    = 32'h0000_00A5;
        mem[1023] = 32'h1122_3344;
        mem[0]    = 32'h5566_7788;
        mem[7]    = 32'h3C5A_A5C3;
        mem[9]    = 32'h0000_00F0;
        mem[12]   = 32'h0000_0055;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.word_count = '0;

        // Reset state
        repeat (3) @(negedge clk_100MHz);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk_100MHz);

        // One word 0xA5 at address 5, tick every clock
        rb = run_len_q.size(); db = done_cnt; ab = addr_q.size(); fb = rx_ferr; lb = rx_q.size();
        issue(10'd5, 11'd1);
        lat = 1;
        check_eq("a5_busy_after_accept", bus.busy, 1);
        check_eq("a5_tx_idle_after_accept", tx, 1);
        while (tx !== 1'b0 && lat < 10) begin
            @(negedge clk_100MHz);
            lat++;
        end
        check_eq("a5_start_latency", lat, 3);
        wait_done("a5", 3000, gaps);
        check_eq("a5_busy_gaps", gaps, 0);
        repeat (5) @(negedge clk_100MHz);
        check_eq("a5_done_pulses", done_cnt - db, 1);
        check_eq("a5_addr_count", addr_q.size() - ab, 1);
        if (addr_q.size() > ab) check_eq("a5_addr0", addr_q[ab], 5);
        exp_b = '{8'hA5, 8'h00, 8'h00, 8'h00};
        check_rx("a5", lb);
        check_eq("a5_framing", rx_ferr - fb, 0);
        exp_run = '{16, 1016, 16, 1016, 32, 1016, 16, 1033, 144, 1017, 144, 1017, 144};
        check_eq("a5_run_count", run_len_q.size() - rb - 1, exp_run.size());
        for (int i = 0; i < exp_run.size(); i++)
            if (rb + 1 + i < run_len_q.size())
                check_eq($sformatf("a5_run%0d", i),
                         run_lvl_q[rb + 1 + i] * 1000 + run_len_q[rb + 1 + i], exp_run[i]);

        // Two words starting at the top address: wraps to 0
        db = done_cnt; ab = addr_q.size(); lb = rx_q.size(); fb = rx_ferr;
        issue(10'd1023, 11'd2);
        wait_done("wrap", 5000, gaps);
        repeat (5) @(negedge clk_100MHz);
        check_eq("wrap_done_pulses", done_cnt - db, 1);
        check_eq("wrap_addr_count", addr_q.size() - ab, 2);
        if (addr_q.size() >= ab + 2) begin
            check_eq("wrap_addr0", addr_q[ab], 1023);
            check_eq("wrap_addr1", addr_q[ab + 1], 0);
        end
        exp_b = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        check_rx("wrap", lb);
        check_eq("wrap_framing", rx_ferr - fb, 0);

        // Empty dump
        db = done_cnt; ab = addr_q.size(); lb = rx_q.size();
        issue(10'd3, 11'd0);
        check_eq("empty_done", bus.done, 1);
        check_eq("empty_busy", bus.busy, 0);
        check_eq("empty_tx", tx, 1);
        @(negedge clk_100MHz);
        check_eq("empty_done_one_clk", bus.done, 0);
        repeat (200) @(negedge clk_100MHz);
        check_eq("empty_done_pulses", done_cnt - db, 1);
        check_eq("empty_no_fetch", addr_q.size() - ab, 0);
        check_eq("empty_no_frames", rx_q.size() - lb, 0);

        // Restart attempt during byte 2 is ignored
        db = done_cnt; lb = rx_q.size(); fb = rx_ferr;
        issue(10'd7, 11'd1);
        n = 0;
        while (rx_q.size() < lb + 2 && n < 2000) begin
            @(negedge clk_100MHz);
            n++;
        end
        check_eq("restart_two_bytes_seen", rx_q.size() - lb, 2);
        repeat (80) @(negedge clk_100MHz);
        issue(10'd0, 11'd5);
        wait_done("restart", 3000, gaps);
        repeat (600) @(negedge clk_100MHz);
        check_eq("restart_done_pulses", done_cnt - db, 1);
        exp_b = '{8'hC3, 8'hA5, 8'h5A, 8'h3C};
        check_rx("restart", lb);
        check_eq("restart_framing", rx_ferr - fb, 0);

        // Reset during data bit 3 of the first frame
        db = done_cnt;
        issue(10'd9, 11'd1);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk_100MHz);
            n++;
        end
        check_eq("abort_start_seen", tx, 0);
        repeat (72) @(negedge clk_100MHz);
        check_eq("abort_bit3_low", tx, 0);
        rst = 1'b1;
        @(negedge clk_100MHz);
        rst = 1'b0;
        check_eq("abort_tx", tx, 1);
        check_eq("abort_busy", bus.busy, 0);
        repeat (200) @(negedge clk_100MHz);
        check_eq("abort_no_done", done_cnt - db, 0);
        check_eq("abort_idle_tx", tx, 1);
        db = done_cnt; lb = rx_q.size(); fb = rx_ferr;
        issue(10'd9, 11'd1);
        wait_done("redump", 3000, gaps);
        repeat (5) @(negedge clk_100MHz);
        check_eq("redump_done_pulses", done_cnt - db, 1);
        exp_b = '{8'hF0, 8'h00, 8'h00, 8'h00};
        check_rx("redump", lb);
        check_eq("redump_framing", rx_ferr - fb, 0);

        // Sample tick every third clock
        tick_div = 3;
        repeat (10) @(negedge clk_100MHz);
        rb = run_len_q.size(); lb = rx_q.size(); fb = rx_ferr;
        issue(10'd12, 11'd1);
        wait_done("slow", 8000, gaps);
        repeat (5) @(negedge clk_100MHz);
        exp_b = '{8'h55, 8'h00, 8'h00, 8'h00};
        check_rx("slow", lb);
        check_eq("slow_framing", rx_ferr - fb, 0);
        check_eq("slow_run_count_ok", run_len_q.size() >= rb + 11, 1);
        if (run_len_q.size() >= rb + 11) begin
            seen = (run_lvl_q[rb + 1] == 1'b0) && (run_len_q[rb + 1] >= 46) && (run_len_q[rb + 1] <= 48);
            check_eq("slow_start_bit", seen, 1);
            for (int i = 0; i < 8; i++)
                check_eq($sformatf("slow_bit%0d", i),
                         run_lvl_q[rb + 2 + i] * 1000 + run_len_q[rb + 2 + i],
                         ((i % 2 == 0) ? 1000 : 0) + 48);
            check_eq("slow_stop_plus_next", run_lvl_q[rb + 10] * 1000 + run_len_q[rb + 10],
                     1000 + SB_TICK * 3 + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
